// File: rtl/wb_hp_pkg.sv
// Shared constants for the wb_hp glitch-detector harness.
//   BASE_ADDR      : address of the single control/status register
//   VCC..GEN       : control bit positions (ctrl register, gpio_i, status)
//   ALARM..CTR_MSB : status bit positions on gpio_o
//   GPIO_ENB       : active-low pad output enables (bits [13:4] driven)
package wb_hp_pkg;
  localparam logic [31:0] BASE_ADDR = 32'h3000_0000;

  localparam int VCC     = 0;
  localparam int ARST    = 1;
  localparam int CRST    = 2;
  localparam int GEN     = 3;
  localparam int ALARM   = 4;
  localparam int LATCH   = 5;
  localparam int CTR_LSB = 6;
  localparam int CTR_MSB = 13;

  localparam logic [15:0] GPIO_ENB = 16'hC00F;
endpackage

// File: rtl/wb_hp_detector.sv
// hp_detector: periodic glitch injector feeding a glitch detector model.
//   clk, srst      : clock and synchronous active-high reset
//   vcc            : supply-present control; gates injector and alarm
//   alarm_rst      : clears the sticky alarm latch (wins over set)
//   alarm_ctr_rst  : clears the alarm counter (wins over increment)
//   glitch_en      : enables the injector (together with vcc)
//   glitch         : registered glitch pulse, GLITCH_LEN cycles every GLITCH_PERIOD
//   alarm          : glitch delayed by one cycle, qualified by vcc
//   alarm_latch    : sticky copy of alarm
//   alarm_ctr      : saturating count of alarm rising edges
module hp_detector #(
  parameter int GLITCH_PERIOD = 16,
  parameter int GLITCH_LEN    = 2
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       vcc,
  input  logic       alarm_rst,
  input  logic       alarm_ctr_rst,
  input  logic       glitch_en,
  output logic       glitch,
  output logic       alarm,
  output logic       alarm_latch,
  output logic [7:0] alarm_ctr
);
  localparam logic [7:0] PHASE_LAST = 8'(GLITCH_PERIOD - 1);
  localparam logic [7:0] PHASE_LEN  = 8'(GLITCH_LEN);

  logic [7:0] phase_reg, phase_next;
  logic       glitch_reg, glitch_next;
  logic       alarm_reg, alarm_next;
  logic       alarm_q_reg;
  logic       latch_reg, latch_next;
  logic [7:0] ctr_reg, ctr_next;
  logic       run;

  always_comb begin
    run         = vcc & glitch_en;
    phase_next  = '0;
    glitch_next = 1'b0;
    if (run) begin
      phase_next  = (phase_reg == PHASE_LAST) ? 8'd0 : phase_reg + 8'd1;
      glitch_next = (phase_reg < PHASE_LEN);
    end

    // One-cycle delay: alarm is still high on the edge where glitch drops.
    alarm_next = glitch_reg & vcc;
    latch_next = alarm_rst ? 1'b0 : (latch_reg | alarm_reg);

    ctr_next = ctr_reg;
    if (alarm_ctr_rst) begin
      ctr_next = 8'd0;
    end else if (alarm_reg && !alarm_q_reg && ctr_reg != 8'hFF) begin
      ctr_next = ctr_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      phase_reg   <= '0;
      glitch_reg  <= 1'b0;
      alarm_reg   <= 1'b0;
      alarm_q_reg <= 1'b0;
      latch_reg   <= 1'b0;
      ctr_reg     <= '0;
    end else begin
      phase_reg   <= phase_next;
      glitch_reg  <= glitch_next;
      alarm_reg   <= alarm_next;
      alarm_q_reg <= alarm_reg;
      latch_reg   <= latch_next;
      ctr_reg     <= ctr_next;
    end
  end

  assign glitch      = glitch_reg;
  assign alarm       = alarm_reg;
  assign alarm_latch = latch_reg;
  assign alarm_ctr   = ctr_reg;
endmodule

// File: rtl/wb_hp.sv
// wb_hp: Wishbone harness around hp_detector.
//   wb_clk_i, reset        : sole clock, synchronous active-high reset
//   user_clock2            : unused, present for pin compatibility
//   wbs_*                  : Wishbone slave, single register at BASE_ADDR
//                            (write ctrl[3:0]; read status), never stalls
//   gpio_i                 : [3:0] control bits, [15:14]==2'b11 enables them
//   gpio_enb, gpio_o       : status pads (alarm, latch, counter)
//   glitch                 : injected glitch pulse
module wb_hp #(
  parameter logic [31:0] BASE_ADDR     = wb_hp_pkg::BASE_ADDR,
  parameter int          GLITCH_PERIOD = 16,
  parameter int          GLITCH_LEN    = 2
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        user_clock2,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_stl_o,
  output logic [31:0] wbs_dat_o,
  input  logic [15:0] gpio_i,
  output logic [15:0] gpio_enb,
  output logic [15:0] gpio_o,
  output logic        glitch
);
  import wb_hp_pkg::*;

  logic        ack_reg;
  logic [31:0] rdata_reg;
  logic [3:0]  ctrl_reg;
  logic [3:0]  eff;
  logic        gpio_ok;
  logic        req;
  logic        hit;
  logic        alarm;
  logic        alarm_latch;
  logic [7:0]  alarm_ctr;
  logic [31:0] status;
  logic        unused_ok;

  assign gpio_ok = (gpio_i[15:14] == 2'b11);

  // Wishbone and pads can each assert a control bit; either one is enough.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_eff
      assign eff[gi] = ctrl_reg[gi] | (gpio_ok & gpio_i[gi]);
    end
  endgenerate

  // A held strobe is not re-accepted while its ack is on the bus.
  assign req    = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign hit    = (wbs_adr_i == BASE_ADDR);
  assign status = {18'b0, alarm_ctr, alarm_latch, alarm, eff};

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
      ctrl_reg  <= '0;
    end else begin
      ack_reg <= req;
      if (req && wbs_we_i && hit) begin
        ctrl_reg <= wbs_dat_i[3:0];
      end
      if (req && !wbs_we_i) begin
        rdata_reg <= hit ? status : 32'd0;
      end
    end
  end

  hp_detector #(
    .GLITCH_PERIOD (GLITCH_PERIOD),
    .GLITCH_LEN    (GLITCH_LEN)
  ) u_det (
    .clk           (wb_clk_i),
    .srst          (reset),
    .vcc           (eff[VCC]),
    .alarm_rst     (eff[ARST]),
    .alarm_ctr_rst (eff[CRST]),
    .glitch_en     (eff[GEN]),
    .glitch        (glitch),
    .alarm         (alarm),
    .alarm_latch   (alarm_latch),
    .alarm_ctr     (alarm_ctr)
  );

  assign wbs_ack_o = ack_reg;
  assign wbs_stl_o = 1'b0;
  assign wbs_dat_o = rdata_reg;
  assign gpio_enb  = GPIO_ENB;
  assign gpio_o    = {2'b0, alarm_ctr, alarm_latch, alarm, 4'b0};

  assign unused_ok = &{1'b0, user_clock2, wbs_dat_i[31:4], gpio_i[13:4]};
endmodule

// File: tb/tb_wb_hp.sv
module tb_wb_hp;
  import wb_hp_pkg::*;

  localparam int P = 16;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        user_clock2 = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, stl, glitch;
  logic [31:0] rdat;
  logic [15:0] gpio_i = '0;
  logic [15:0] gpio_enb, gpio_o;

  always #5 clk = ~clk;

  wb_hp #(.BASE_ADDR(BASE_ADDR), .GLITCH_PERIOD(P), .GLITCH_LEN(L)) dut (
    .wb_clk_i    (clk),
    .reset       (reset),
    .user_clock2 (user_clock2),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_stl_o   (stl),
    .wbs_dat_o   (rdat),
    .gpio_i      (gpio_i),
    .gpio_enb    (gpio_enb),
    .gpio_o      (gpio_o),
    .glitch      (glitch)
  );

  // Reference model: the injector is described by how many consecutive
  // cycles it has been enabled; the glitch is high for the first L cycles
  // of every P-cycle window of that run.
  int          m_run = 0;
  bit          m_glitch = 0, m_alarm = 0, m_alarm_prev = 0, m_latch = 0;
  int          m_ctr = 0;
  logic [3:0]  m_ctrl = '0;
  bit          m_ack = 0;
  logic [31:0] m_dat = '0;
  bit          m_fell = 0;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [3:0]  e;
    logic [31:0] st, d_n;
    logic [3:0]  c_n;
    bit req, run, g_n, a_n, ap_n, l_n, ack_n;
    int run_n, ctr_n;
    e    = m_ctrl | ((gpio_i[15:14] == 2'b11) ? gpio_i[3:0] : 4'b0);
    req  = cyc && stb && !m_ack;
    run  = e[VCC] && e[GEN];
    st   = {18'b0, 8'(m_ctr), m_latch, m_alarm, e};
    if (reset) begin
      g_n = 0; run_n = 0; a_n = 0; ap_n = 0; l_n = 0; ctr_n = 0;
      ack_n = 0; c_n = '0; d_n = '0;
    end else begin
      g_n   = run && ((m_run % P) < L);
      run_n = run ? m_run + 1 : 0;
      a_n   = m_glitch && e[VCC];
      ap_n  = m_alarm;
      l_n   = e[ARST] ? 1'b0 : (m_latch || m_alarm);
      if (e[CRST])                      ctr_n = 0;
      else if (m_alarm && !m_alarm_prev) ctr_n = (m_ctr < 255) ? m_ctr + 1 : 255;
      else                              ctr_n = m_ctr;
      ack_n = req;
      c_n   = (req && we && adr == BASE_ADDR) ? wdat[3:0] : m_ctrl;
      d_n   = (req && !we) ? ((adr == BASE_ADDR) ? st : 32'd0) : m_dat;
    end
    @(posedge clk);
    m_fell = m_glitch && !g_n;
    m_glitch = g_n; m_run = run_n; m_alarm = a_n; m_alarm_prev = ap_n;
    m_latch = l_n; m_ctr = ctr_n; m_ack = ack_n; m_ctrl = c_n; m_dat = d_n;
    #1;
    check("glitch", glitch, m_glitch);
    check("gpio_o", gpio_o, {2'b0, 8'(m_ctr), m_latch, m_alarm, 4'b0});
    check("ack", ack, m_ack);
    check("dat_o", rdat, m_dat);
    check("stall", stl, 0);
    check("gpio_enb", gpio_enb, 16'hC00F);
  endtask

  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    tick();
    check("ack_pulse_hi", ack, 1);
    r = rdat;
    cyc = 0; stb = 0; we = 0;
    tick();
    check("ack_pulse_lo", ack, 0);
    $display("wb %s adr=%h wdat=%h rdat=%h", w ? "WR" : "RD", a, d, r);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] r;
    int saved_ctr;
    bit found;

    tbl[0] = '{0, BASE_ADDR,     32'h0, 32'h0};
    tbl[1] = '{1, BASE_ADDR,     32'h1, 32'h0};
    tbl[2] = '{0, BASE_ADDR,     32'h0, 32'h1};
    tbl[3] = '{1, BASE_ADDR,     32'h8, 32'h0};
    tbl[4] = '{0, BASE_ADDR,     32'h0, 32'h8};
    tbl[5] = '{1, BASE_ADDR + 4, 32'hF, 32'h0};
    tbl[6] = '{0, BASE_ADDR,     32'h0, 32'h8};
    tbl[7] = '{0, BASE_ADDR + 4, 32'h0, 32'h0};
    tbl[8] = '{1, BASE_ADDR,     32'h0, 32'h0};
    tbl[9] = '{0, BASE_ADDR,     32'h0, 32'h0};

    reset = 1;
    tick(); tick();
    reset = 0;
    tick();

    // Register access table with GPIO control disabled.
    for (int i = 0; i < 10; i++) begin
      wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].wdat, r);
      if (!tbl[i].we) check($sformatf("tbl_rd%0d", i), r, tbl[i].exp);
    end

    // GPIO-driven glitching: alarm must be high at every glitch fall.
    gpio_i = 16'hC009;
    for (int i = 0; i < 230; i++) begin
      tick();
      if (m_fell) check("alarm_at_fall", gpio_o[ALARM], 1);
    end
    check("ctr_ge8", (gpio_o[CTR_MSB:CTR_LSB] >= 8) ? 1 : 0, 1);
    check("latch_set", gpio_o[LATCH], 1);

    // Counter clear pulse with injector off.
    gpio_i = 16'hC001;
    repeat (3) tick();
    gpio_i = 16'hC005;
    tick();
    gpio_i = 16'hC001;
    tick(); tick();
    check("ctr_cleared", gpio_o[CTR_MSB:CTR_LSB], 0);
    check("latch_kept", gpio_o[LATCH], 1);

    // Build a nonzero count, then clear only the latch.
    gpio_i = 16'hC009;
    repeat (40) tick();
    gpio_i = 16'hC001;
    repeat (3) tick();
    saved_ctr = m_ctr;
    gpio_i = 16'hC003;
    tick();
    gpio_i = 16'hC001;
    tick();
    check("latch_cleared", gpio_o[LATCH], 0);
    check("ctr_kept", gpio_o[CTR_MSB:CTR_LSB], 32'(saved_ctr));
    check("ctr_kept_nz", (saved_ctr > 0) ? 1 : 0, 1);

    // Saturation: more than 255 glitches.
    gpio_i = 16'hC009;
    repeat (255 * P + 200) tick();
    check("ctr_sat", gpio_o[CTR_MSB:CTR_LSB], 255);

    // Wishbone-driven clears (GPIO control off).
    gpio_i = 16'h0000;
    wb_xfer(1, BASE_ADDR, 32'h3, r);
    repeat (3) tick();
    wb_xfer(1, BASE_ADDR, 32'h1, r);
    wb_xfer(0, BASE_ADDR, 32'h0, r);
    check("wb_latch_clr", r[5], 0);
    check("wb_ctr_still", r[13:6], 255);
    wb_xfer(1, BASE_ADDR, 32'h5, r);
    repeat (2) tick();
    wb_xfer(1, BASE_ADDR, 32'h1, r);
    wb_xfer(0, BASE_ADDR, 32'h0, r);
    check("wb_ctr_clr", r[13:6], 0);
    check("wb_vcc_bit", r[0], 1);

    // Reset while the glitch is high, with a read in flight.
    gpio_i = 16'hC009;
    wb_xfer(0, BASE_ADDR, 32'h0, r);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (m_glitch) found = 1;
    end
    check("glitch_seen", found, 1);
    reset = 1; cyc = 1; stb = 1; we = 0; adr = BASE_ADDR;
    tick();
    check("rst_glitch", glitch, 0);
    check("rst_gpio_o", gpio_o, 0);
    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    reset = 0; cyc = 0; stb = 0;
    gpio_i = 16'h0000;
    tick();
    wb_xfer(0, BASE_ADDR, 32'h0, r);
    check("rst_ctrl", r, 0);
    gpio_i = 16'hC001;
    wb_xfer(0, BASE_ADDR, 32'h0, r);
    check("gpio_vcc_rd", r, 1);
    wb_xfer(0, BASE_ADDR + 4, 32'h0, r);
    check("other_adr_rd", r, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      gpio_i = 16'($urandom);
      gpio_i[15:14] = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'b00;
      gpio_i[VCC]  = ($urandom_range(0, 7) != 0);
      gpio_i[GEN]  = ($urandom_range(0, 7) != 0);
      gpio_i[ARST] = ($urandom_range(0, 31) == 0);
      gpio_i[CRST] = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) begin
        wb_xfer(1'($urandom), ($urandom_range(0, 3) == 0) ? BASE_ADDR + 4 : BASE_ADDR,
                $urandom & 32'hFFFF_FFF9, r);
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
